// File: rtl/apb4_master_bridge_pkg.sv
// Purpose : shared types and helpers for the APB4 initiator bridge.
// Contents: FSM state encoding, default PPROT value, timeout counter width helper.
package apb4_master_bridge_pkg;

    // Bridge FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        APB4_MST_IDLE   = 2'd0,
        APB4_MST_SETUP  = 2'd1,
        APB4_MST_ACCESS = 2'd2,
        APB4_MST_RESP   = 2'd3
    } apb4_mst_state_e;

    localparam int unsigned PPROT_W = 3;

    // PPROT value driven out of reset: normal, secure, data access
    localparam logic [PPROT_W-1:0] APB4_MST_PPROT_DEFAULT = 3'b000;

    // Timeout counter width; a disabled timeout (limit 0) still needs one bit
    function automatic int unsigned apb4_mst_tmo_width(input int unsigned limit);
        int unsigned w;
        w = (limit == 0) ? 1 : $clog2(limit + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage : apb4_master_bridge_pkg

// File: rtl/apb4_mst_timeout.sv
// Purpose : saturating cycle counter that flags the last allowed cycle of a
//           bounded wait. Reusable by any initiator needing a response bound.
// Ports   : pclk, presetn (sync, active-low)
//           clr_i    - restart counting from zero
//           en_i     - count this cycle
//           expire_o - registered; high while the count equals LIMIT-1
//                      (never high when LIMIT is 0)
module apb4_mst_timeout
    import apb4_master_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = apb4_mst_tmo_width(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Next count: clear wins over enable, hold at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Flag tracks the count it is registered with, so it stays a pure flop output
        expire_d = (LIMIT != 0) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire_o = expire_q;

endmodule : apb4_mst_timeout

// File: rtl/apb4_master_bridge.sv
// Purpose : single-outstanding APB4 initiator converting a valid/ready
//           request/response channel into APB4 SETUP/ACCESS transfers, with a
//           programmable PREADY timeout so every accepted request is answered.
// Ports   : pclk, presetn (sync, active-low)
//           req_*  - request channel (valid/ready, addr, write, wdata, strb, prot)
//           rsp_*  - response channel (valid/ready, rdata, err, timeout)
//           p*_o   - APB4 initiator outputs; pready_i/prdata_i/pslverr_i from slave
//           busy_o - high whenever a transfer is in flight (state not IDLE)
module apb4_master_bridge
    import apb4_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    presetn,
    // request channel
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,
    // response channel
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    // APB4 initiator
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i,
    // status
    output logic                    busy_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    apb4_mst_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic tmo_clr, tmo_en, tmo_expire;

    // Bounds the ACCESS phase; cleared during SETUP so ACCESS starts at zero
    apb4_mst_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .pclk     (pclk),
        .presetn  (presetn),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    // Ready is forced low while reset is applied so nothing is offered pre-release
    assign req_ready_o = presetn && (state_q == APB4_MST_IDLE);
    assign busy_o      = (state_q != APB4_MST_IDLE);

    // Next-state and registered-output decode
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        rsp_valid_d   = 1'b0;
        tmo_clr       = 1'b0;
        tmo_en        = 1'b0;

        unique case (state_q)
            APB4_MST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    paddr_d  = req_addr_i;
                    pprot_d  = req_prot_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    // Reads must present an all-zero strobe
                    pstrb_d  = req_write_i ? req_strb_i : '0;
                    psel_d   = 1'b1;
                    state_d  = APB4_MST_SETUP;
                end
            end

            APB4_MST_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                tmo_clr   = 1'b1;
                state_d   = APB4_MST_ACCESS;
            end

            APB4_MST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                tmo_en    = 1'b1;
                // Slave response takes priority over a coincident timeout
                if (pready_i) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = APB4_MST_RESP;
                end else if (tmo_expire) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = APB4_MST_RESP;
                end
            end

            APB4_MST_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = APB4_MST_IDLE;
                end
            end

            default: begin
                state_d = APB4_MST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q       <= APB4_MST_IDLE;
            paddr_q       <= '0;
            pprot_q       <= APB4_MST_PPROT_DEFAULT;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign paddr_o       = paddr_q;
    assign pprot_o       = pprot_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule : apb4_master_bridge
